// File: rtl/seq_ctrl_pkg.sv
// Shared types and default widths for the serial pattern-detector run controller.
// Contents: state_t (IDLE, ARM, RUN, DONE) and default PAT_W / CNT_W / TMO_W.
// No logic lives here; it only fixes the encodings that the controller files share.
package seq_ctrl_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pat_shift.sv
// History shift register, fill counter and pattern compare for one detector.
// Latency: hit is combinational in the sampling cycle; the history updates on the next edge.
// Backpressure: none; a bit is taken on every cycle that shift is high.
// Ports: clk, rst_n (async, active-low); clr empties history and fill; shift takes bit_in
//   into the LSB; pattern is compared against the updated history (MSB = oldest bit);
//   clr_fill drops the fill count back to 0 when a hit occurs; hit flags a full-window match.
module seq_pat_shift
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             clr_fill,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill;
  logic              full_nxt;

  // Casting the concatenation drops the oldest bit, so this also holds for PAT_W = 1.
  assign hist_nxt = PAT_W'({hist, bit_in});
  // The window is full once the incoming bit brings fill to PAT_W.
  assign full_nxt = (fill >= FILL_W'(PAT_W - 1));
  assign hit      = shift && full_nxt && (hist_nxt == pattern);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      // Dropping fill is enough for non-overlap: the next hit needs PAT_W fresh bits.
      if (hit && clr_fill) begin
        fill <= '0;
      end else if (fill != FULL) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: arms on start, scans the gated serial stream for a latched pattern,
// counts matches and ends on a match target, a RUN-cycle timeout or an abort.
// Latency: match_pulse / match_cnt follow the sampling cycle by one clock; done coincides
//   with the final match_pulse or follows the last timeout cycle.
// Backpressure: none; in is consumed on every in_valid cycle while in RUN.
// Ports: cfg_* are latched on an accepted start; start/abort are control strobes;
//   in/in_valid form the serial input; busy, match_pulse, match_cnt, done and timeout
//   report status.
// Optional: define SEQ_CTRL_FIRST_POS_EN to add first_pos, the number of valid bits
//   taken since ARM up to and including the bit that completed the first match of a run.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             in,
  input  logic             in_valid,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout
`ifdef SEQ_CTRL_FIRST_POS_EN
  ,
  output logic [TMO_W-1:0] first_pos
`endif
);

  state_t           state;
  state_t           state_nxt;

  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] cyc_cnt;

  logic             in_run;
  logic             take_start;
  logic             hit;
  logic             hit_run;
  logic             tgt_exit;
  logic             tmo_exit;
  logic [CNT_W-1:0] cnt_inc;

  assign in_run     = (state == RUN);
  assign take_start = (state == IDLE) && start && !abort;
  // An abort in the same cycle swallows the match so match_cnt stays held.
  assign hit_run    = hit && !abort;
  assign cnt_inc    = (&match_cnt) ? match_cnt : (match_cnt + CNT_W'(1));
  assign tgt_exit   = hit_run && (tgt_q != '0) && (cnt_inc == tgt_q);
  assign tmo_exit   = in_run && !abort && (tmo_q != '0) && (cyc_cnt == (tmo_q - TMO_W'(1)));

  seq_pat_shift #(
    .PAT_W(PAT_W)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == ARM),
    .shift   (in_run && in_valid),
    .bit_in  (in),
    .pattern (pat_q),
    .clr_fill(!ovl_q),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ARM;
      end
      ARM: begin
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (tgt_exit || tmo_exit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      tmo_q       <= '0;
      cyc_cnt     <= '0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
      timeout     <= 1'b0;
    end else begin
      if (take_start) begin
        pat_q     <= cfg_pattern;
        ovl_q     <= cfg_overlap;
        tgt_q     <= cfg_target;
        tmo_q     <= cfg_timeout;
        match_cnt <= '0;
        timeout   <= 1'b0;
      end
      if (state == ARM) begin
        cyc_cnt <= '0;
      end else if (in_run) begin
        cyc_cnt <= cyc_cnt + TMO_W'(1);
      end
      match_pulse <= hit_run;
      if (hit_run) begin
        match_cnt <= cnt_inc;
      end
      // A target hit on the last timeout cycle ends the run as a normal completion.
      if (tmo_exit && !tgt_exit) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef SEQ_CTRL_FIRST_POS_EN
  logic [TMO_W-1:0] vld_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_cnt   <= '0;
      first_pos <= '0;
    end else begin
      if (state == ARM) begin
        vld_cnt <= '0;
      end else if (in_run && in_valid && (vld_cnt != '1)) begin
        vld_cnt <= vld_cnt + TMO_W'(1);
      end
      if (take_start) begin
        first_pos <= '0;
      end else if (hit_run && (match_cnt == '0)) begin
        // match_cnt is zero only before the first match of the run.
        first_pos <= vld_cnt + TMO_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed runs plus randomized runs, each
// compared cycle by cycle against a queue-based reference model of the detector rules.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int TMO_W = 16;
  localparam int MAXN  = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic [TMO_W-1:0] cfg_timeout;
  logic             start;
  logic             abort;
  logic             in;
  logic             in_valid;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             timeout;
`ifdef SEQ_CTRL_FIRST_POS_EN
  logic [TMO_W-1:0] first_pos;
`endif

  seq_detect_ctrl #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .TMO_W(TMO_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .cfg_timeout(cfg_timeout),
    .start      (start),
    .abort      (abort),
    .in         (in),
    .in_valid   (in_valid),
    .busy       (busy),
    .match_pulse(match_pulse),
    .match_cnt  (match_cnt),
    .done       (done),
    .timeout    (timeout)
`ifdef SEQ_CTRL_FIRST_POS_EN
    ,
    .first_pos  (first_pos)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Run description: latched config plus per-RUN-cycle stimulus.
  int m_pat, m_ovl, m_tgt, m_tmo, st_len;
  bit st_v[MAXN];
  bit st_b[MAXN];
  bit st_ab[MAXN];

  // Model expectations, indexed by observation slot (slot 0 = after the start edge).
  int e_n;
  bit e_busy[MAXN];
  bit e_pulse[MAXN];
  bit e_done[MAXN];
  bit e_tmo[MAXN];
  int e_cnt[MAXN];
  int e_fp;
  int e_final_cnt;
  bit e_final_tmo;

  // DUT observations, same indexing.
  int               o_n;
  logic             o_busy[MAXN];
  logic             o_pulse[MAXN];
  logic             o_done[MAXN];
  logic             o_tmo[MAXN];
  logic [CNT_W-1:0] o_cnt[MAXN];

  // Stimulus string: '1'/'0' valid bits, '_' gap, 'a' abort.
  task automatic load(input string s);
    byte c;
    st_len = s.len();
    for (int i = 0; i < st_len; i++) begin
      c        = s[i];
      st_v[i]  = (c == "1") || (c == "0");
      st_b[i]  = (c == "1");
      st_ab[i] = (c == "a");
    end
  endtask

  task automatic set_cfg(input int p, input int o, input int tg, input int tm);
    m_pat = p; m_ovl = o; m_tgt = tg; m_tmo = tm;
  endtask

  // Reference model: recent valid bits in a queue, a match whenever the last PAT_W of
  // them spell the pattern, queue emptied after a match when overlap is off.
  task automatic model_run();
    int  hq[$];
    int  cnt, vcnt, t, t_end, val;
    bit  tmo_f, ended, v, b, ab, m, tg, tm;
    cnt = 0; vcnt = 0; tmo_f = 0; ended = 0; t_end = 0; e_fp = 0;
    for (int k = 0; k < 2; k++) begin
      e_busy[k] = 1; e_pulse[k] = 0; e_done[k] = 0; e_tmo[k] = 0; e_cnt[k] = 0;
    end
    for (int j = 0; j <= st_len && !ended; j++) begin
      v  = (j < st_len) ? st_v[j]  : 1'b0;
      b  = (j < st_len) ? st_b[j]  : 1'b0;
      ab = (j < st_len) ? st_ab[j] : 1'b0;
      t  = j + 2;
      if (ab) begin
        e_busy[t] = 0; e_pulse[t] = 0; e_done[t] = 0; e_cnt[t] = cnt; e_tmo[t] = 0;
        ended = 1; t_end = t;
      end else begin
        m = 0;
        if (v) begin
          vcnt++;
          hq.push_back(int'(b));
          if (hq.size() > PAT_W) void'(hq.pop_front());
          if (hq.size() == PAT_W) begin
            val = 0;
            foreach (hq[i]) val = val * 2 + hq[i];
            m = (val == m_pat);
          end
          if (m && (m_ovl == 0)) hq.delete();
        end
        if (m) begin
          if (cnt == 0) e_fp = vcnt;
          if (cnt < 255) cnt++;
        end
        tg = m && (m_tgt != 0) && (cnt == m_tgt);
        tm = (m_tmo != 0) && (j == m_tmo - 1);
        if (tm && !tg) tmo_f = 1;
        e_pulse[t] = m; e_cnt[t] = cnt; e_done[t] = tg || tm; e_busy[t] = !(tg || tm);
        e_tmo[t] = tmo_f;
        if (tg || tm) begin ended = 1; t_end = t; end
      end
    end
    if (ended) begin
      t = t_end + 1;
      e_busy[t] = 0; e_pulse[t] = 0; e_done[t] = 0; e_cnt[t] = cnt; e_tmo[t] = tmo_f;
      e_n = t_end + 2;
    end else begin
      e_n = st_len + 3;
    end
    e_final_cnt = cnt;
    e_final_tmo = tmo_f;
  endtask

  task automatic rec(input int t);
    o_busy[t] = busy; o_pulse[t] = match_pulse; o_done[t] = done;
    o_tmo[t]  = timeout; o_cnt[t] = match_cnt;
  endtask

  // Drives one run: start cycle, ARM cycle with junk input, then the stimulus with
  // scrambled cfg_* and random start strobes while the DUT is still busy.
  task automatic do_run();
    int t;
    bit stop;
    t = 0; stop = 0;
    cfg_pattern = PAT_W'(m_pat); cfg_overlap = 1'(m_ovl);
    cfg_target  = CNT_W'(m_tgt); cfg_timeout = TMO_W'(m_tmo);
    start = 1; abort = 0;
    in = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
    @(posedge clk); #1; rec(t); t++;
    start = 0;
    cfg_pattern = PAT_W'($urandom); cfg_overlap = 1'($urandom_range(0, 1));
    cfg_target  = CNT_W'($urandom); cfg_timeout = TMO_W'($urandom);
    in = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
    @(posedge clk); #1; rec(t); t++;
    for (int j = 0; j <= st_len && !stop; j++) begin
      in_valid = (j < st_len) ? st_v[j]  : 1'b0;
      in       = (j < st_len) ? st_b[j]  : 1'b0;
      abort    = (j < st_len) ? st_ab[j] : 1'b0;
      start    = 1'($urandom_range(0, 1));
      @(posedge clk); #1; rec(t); t++;
      if (busy !== 1'b1) stop = 1;
    end
    start = 0; abort = 0; in_valid = 0; in = 0;
    if (stop) begin
      @(posedge clk); #1; rec(t); t++;
    end
    o_n = t;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; abort = 0; in = 0; in_valid = 0;
    cfg_pattern = '0; cfg_overlap = 0; cfg_target = '0; cfg_timeout = '0;
    #12;
    checks++;
    if ({busy, match_pulse, done, timeout, match_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy/pulse/done/tmo/cnt=%b/%b/%b/%b/%0d want all 0",
               busy, match_pulse, done, timeout, match_cnt);
    end
`ifdef SEQ_CTRL_FIRST_POS_EN
    checks++;
    if (first_pos !== '0) begin
      errors++;
      $display("FAIL reset_first_pos: got %0d want 0", first_pos);
    end
`endif
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_target_exit();
    string nm = "target";
    set_cfg(4'b1100, 0, 2, 0); load("11001100");
    model_run(); do_run();
    checks++;
    if (o_n != e_n) begin errors++; $display("FAIL %s run_length: got %0d want %0d", nm, o_n, e_n); end
    for (int t = 0; t < e_n && t < o_n; t++) begin
      checks++;
      if ({o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t]} !==
          {e_busy[t], e_pulse[t], e_done[t], e_tmo[t], CNT_W'(e_cnt[t])}) begin
        errors++;
        $display("FAIL %s t=%0d busy/pulse/done/tmo/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm, t,
                 o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t], e_busy[t], e_pulse[t], e_done[t], e_tmo[t], e_cnt[t]);
      end
    end
    // 4th bit sampled in slot 5, 8th bit in slot 9 where done coincides.
    checks++;
    if (!(o_pulse[5] === 1'b1 && o_cnt[5] === 8'd1 && o_pulse[9] === 1'b1 && o_done[9] === 1'b1 &&
          o_cnt[9] === 8'd2 && o_busy[10] === 1'b0)) begin
      errors++;
      $display("FAIL %s key_slots: got pulse5=%b cnt5=%0d pulse9=%b done9=%b cnt9=%0d busy10=%b want 1/1/1/1/2/0",
               nm, o_pulse[5], o_cnt[5], o_pulse[9], o_done[9], o_cnt[9], o_busy[10]);
    end
  endtask

  task automatic test_overlap();
    string nm;
    int    want;
    bit    saw_done;
    for (int ov = 1; ov >= 0; ov--) begin
      nm = (ov != 0) ? "overlap1" : "overlap0";
      // Seven bits 1010101 hold two overlapping 1010 windows, one without overlap.
      want = (ov != 0) ? 2 : 1;
      set_cfg(4'b1010, ov, 0, 0); load("1010101a");
      model_run(); do_run();
      checks++;
      if (o_n != e_n) begin errors++; $display("FAIL %s run_length: got %0d want %0d", nm, o_n, e_n); end
      for (int t = 0; t < e_n && t < o_n; t++) begin
        checks++;
        if ({o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t]} !==
            {e_busy[t], e_pulse[t], e_done[t], e_tmo[t], CNT_W'(e_cnt[t])}) begin
          errors++;
          $display("FAIL %s t=%0d busy/pulse/done/tmo/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm, t,
                   o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t], e_busy[t], e_pulse[t], e_done[t], e_tmo[t], e_cnt[t]);
        end
      end
      saw_done = 0;
      for (int t = 0; t < o_n; t++) if (o_done[t] === 1'b1) saw_done = 1;
      checks++;
      if (saw_done || o_cnt[o_n-1] !== CNT_W'(want)) begin
        errors++;
        $display("FAIL %s abort_end: got done_seen=%b cnt=%0d want 0/%0d", nm, saw_done, o_cnt[o_n-1], want);
      end
    end
  endtask

  task automatic test_gaps();
    string nm = "gaps";
    int    np;
    set_cfg(4'b1100, 0, 0, 0); load("11__00_a");
    model_run(); do_run();
    checks++;
    if (o_n != e_n) begin errors++; $display("FAIL %s run_length: got %0d want %0d", nm, o_n, e_n); end
    for (int t = 0; t < e_n && t < o_n; t++) begin
      checks++;
      if ({o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t]} !==
          {e_busy[t], e_pulse[t], e_done[t], e_tmo[t], CNT_W'(e_cnt[t])}) begin
        errors++;
        $display("FAIL %s t=%0d busy/pulse/done/tmo/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm, t,
                 o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t], e_busy[t], e_pulse[t], e_done[t], e_tmo[t], e_cnt[t]);
      end
    end
    np = 0;
    for (int t = 0; t < o_n; t++) if (o_pulse[t] === 1'b1) np++;
    checks++;
    if (np != 1) begin errors++; $display("FAIL %s pulse_count: got %0d want 1", nm, np); end
  endtask

  task automatic test_timeout();
    string nm = "timeout";
    set_cfg(4'b1100, 0, 0, 10); load("1111111111111");
    model_run(); do_run();
    checks++;
    if (o_n != e_n) begin errors++; $display("FAIL %s run_length: got %0d want %0d", nm, o_n, e_n); end
    for (int t = 0; t < e_n && t < o_n; t++) begin
      checks++;
      if ({o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t]} !==
          {e_busy[t], e_pulse[t], e_done[t], e_tmo[t], CNT_W'(e_cnt[t])}) begin
        errors++;
        $display("FAIL %s t=%0d busy/pulse/done/tmo/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm, t,
                 o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t], e_busy[t], e_pulse[t], e_done[t], e_tmo[t], e_cnt[t]);
      end
    end
    // Slot 0 is the ARM cycle; done must show 11 cycles later.
    checks++;
    if (!(o_busy[10] === 1'b1 && o_done[11] === 1'b1 && o_tmo[11] === 1'b1 && o_cnt[11] === 8'd0)) begin
      errors++;
      $display("FAIL %s done_slot: got busy10=%b done11=%b tmo11=%b cnt11=%0d want 1/1/1/0",
               nm, o_busy[10], o_done[11], o_tmo[11], o_cnt[11]);
    end
  endtask

  task automatic test_abort_start();
    logic [CNT_W-1:0] held_cnt;
    logic             held_tmo;
    held_cnt = CNT_W'(e_final_cnt); held_tmo = e_final_tmo;
    cfg_pattern = PAT_W'($urandom); cfg_target = CNT_W'($urandom); cfg_timeout = TMO_W'($urandom);
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    checks++;
    if ({busy, done, match_cnt, timeout} !== {1'b0, 1'b0, held_cnt, held_tmo}) begin
      errors++;
      $display("FAIL abort_start: got busy/done/cnt/tmo=%b/%b/%0d/%b want 0/0/%0d/%b",
               busy, done, match_cnt, timeout, held_cnt, held_tmo);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_tgt_tmo();
    string nm = "tgt_tmo";
    set_cfg(4'b1100, 0, 1, 4); load("1100");
    model_run(); do_run();
    checks++;
    if (o_n != e_n) begin errors++; $display("FAIL %s run_length: got %0d want %0d", nm, o_n, e_n); end
    for (int t = 0; t < e_n && t < o_n; t++) begin
      checks++;
      if ({o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t]} !==
          {e_busy[t], e_pulse[t], e_done[t], e_tmo[t], CNT_W'(e_cnt[t])}) begin
        errors++;
        $display("FAIL %s t=%0d busy/pulse/done/tmo/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm, t,
                 o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t], e_busy[t], e_pulse[t], e_done[t], e_tmo[t], e_cnt[t]);
      end
    end
    checks++;
    if (!(o_done[5] === 1'b1 && o_tmo[5] === 1'b0 && o_cnt[5] === 8'd1 && o_tmo[6] === 1'b0)) begin
      errors++;
      $display("FAIL %s priority: got done=%b tmo=%b cnt=%0d tmo_after=%b want 1/0/1/0",
               nm, o_done[5], o_tmo[5], o_cnt[5], o_tmo[6]);
    end
  endtask

  task automatic test_saturate();
    cfg_pattern = '0; cfg_overlap = 1; cfg_target = '0; cfg_timeout = '0;
    start = 1; abort = 0; in_valid = 0; in = 0;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    in_valid = 1; in = 0;
    repeat (262) @(posedge clk);
    #1;
    checks++;
    if ({busy, match_pulse, match_cnt} !== {1'b1, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL saturate: got busy/pulse/cnt=%b/%b/%0d want 1/1/255", busy, match_pulse, match_cnt);
    end
    in_valid = 0; abort = 1;
    @(posedge clk); #1; abort = 0;
    checks++;
    if ({busy, done, match_cnt} !== {1'b0, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL saturate_abort: got busy/done/cnt=%b/%b/%0d want 0/0/255", busy, done, match_cnt);
    end
  endtask

`ifdef SEQ_CTRL_FIRST_POS_EN
  task automatic test_first_pos();
    set_cfg(4'b1100, 0, 1, 0); load("0111100");
    model_run(); do_run();
    // 0111100: the window ending at the seventh valid bit is 1100.
    checks++;
    if (first_pos !== TMO_W'(7) || first_pos !== TMO_W'(e_fp)) begin
      errors++;
      $display("FAIL first_pos: got %0d want 7 (model %0d)", first_pos, e_fp);
    end
  endtask
`endif

  task automatic test_random();
    string nm = "random";
    for (int r = 0; r < 40; r++) begin
      set_cfg($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3),
              ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30));
      st_len = $urandom_range(4, 40);
      for (int j = 0; j < st_len; j++) begin
        st_v[j]  = ($urandom_range(0, 3) != 0);
        // Mostly replay the pattern so matches are frequent.
        st_b[j]  = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1))
                                               : 1'((m_pat >> (PAT_W - 1 - (j % PAT_W))) & 1);
        st_ab[j] = ($urandom_range(0, 39) == 0);
      end
      st_ab[st_len-1] = 1;
      model_run(); do_run();
      checks++;
      if (o_n != e_n) begin errors++; $display("FAIL %s r=%0d run_length: got %0d want %0d", nm, r, o_n, e_n); end
      for (int t = 0; t < e_n && t < o_n; t++) begin
        checks++;
        if ({o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t]} !==
            {e_busy[t], e_pulse[t], e_done[t], e_tmo[t], CNT_W'(e_cnt[t])}) begin
          errors++;
          $display("FAIL %s r=%0d t=%0d busy/pulse/done/tmo/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm, r, t,
                   o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t], e_busy[t], e_pulse[t], e_done[t], e_tmo[t], e_cnt[t]);
        end
      end
`ifdef SEQ_CTRL_FIRST_POS_EN
      checks++;
      if (first_pos !== TMO_W'(e_fp)) begin
        errors++;
        $display("FAIL %s r=%0d first_pos: got %0d want %0d", nm, r, first_pos, e_fp);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    string nm = "async_reset";
    set_cfg(4'b1100, 0, 0, 0); load("110011001100");
    model_run(); do_run();
    checks++;
    if (o_n != e_n) begin errors++; $display("FAIL %s run_length: got %0d want %0d", nm, o_n, e_n); end
    for (int t = 0; t < e_n && t < o_n; t++) begin
      checks++;
      if ({o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t]} !==
          {e_busy[t], e_pulse[t], e_done[t], e_tmo[t], CNT_W'(e_cnt[t])}) begin
        errors++;
        $display("FAIL %s t=%0d busy/pulse/done/tmo/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", nm, t,
                 o_busy[t], o_pulse[t], o_done[t], o_tmo[t], o_cnt[t], e_busy[t], e_pulse[t], e_done[t], e_tmo[t], e_cnt[t]);
      end
    end
    checks++;
    if ({busy, match_cnt} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL %s pre_reset: got busy/cnt=%b/%0d want 1/3", nm, busy, match_cnt);
    end
    // Assert reset between clock edges: outputs must clear without a clock.
    #3; rst_n = 0;
    #1;
    checks++;
    if ({busy, match_pulse, done, timeout, match_cnt} !== '0) begin
      errors++;
      $display("FAIL %s immediate: got busy/pulse/done/tmo/cnt=%b/%b/%b/%b/%0d want all 0",
               nm, busy, match_pulse, done, timeout, match_cnt);
    end
`ifdef SEQ_CTRL_FIRST_POS_EN
    checks++;
    if (first_pos !== '0) begin
      errors++;
      $display("FAIL %s first_pos: got %0d want 0", nm, first_pos);
    end
`endif
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b want 0", nm, busy);
    end
  endtask

  initial begin
    test_reset();
    test_target_exit();
    test_overlap();
    test_gaps();
    test_timeout();
    test_abort_start();
    test_tgt_tmo();
    test_saturate();
`ifdef SEQ_CTRL_FIRST_POS_EN
    test_first_pos();
`endif
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
